ctr_record_queue: RTL and testbench

- Next-generation control transfer record emitter for the CTR unit.
- Takes the instructions retired on all commit ports and pairs each control transfer with its target. The target is the PC of the next retired instruction, in the same cycle or a later one.
- Filters records by type, tags each with a saturating cycle count, and buffers them in a multi-write FIFO.
- The CTR buffer drains the FIFO one record per cycle over a valid/ready handshake.

---
 rtl/ctr_record_queue.sv | 225 ++++++++++++++++++++++
 tb/tb_ctr_record_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctr_record_queue.sv
// Control transfer record emitter.
// Pairs each retired control transfer with the PC of the next retired
// instruction, filters by type, tags with a saturating cycle count and
// buffers the surviving records in a multi-write FIFO drained one per cycle.

// Per-candidate filter: keeps a record unless frozen or its type is inhibited.
module ctr_record_queue_filt (
  input  logic        vld_i,
  input  logic [3:0]  type_i,
  input  logic [15:0] inhibit_mask_i,
  input  logic        freeze_i,
  output logic        keep_o
);
  assign keep_o = vld_i & ~freeze_i & ~inhibit_mask_i[type_i];
endmodule

module ctr_record_queue #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned CcWidth       = 16
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic [NrCommitPorts*XLEN-1:0]      source_i,
  input  logic [NrCommitPorts*4-1:0]         type_i,
  input  logic [NrCommitPorts-1:0]           valid_i,
  input  logic [15:0]                        inhibit_mask_i,
  input  logic                               freeze_i,
  input  logic                               flush_i,
  output logic                               rec_valid_o,
  input  logic                               rec_ready_i,
  output logic [XLEN-2:0]                    rec_source_o,
  output logic [XLEN-2:0]                    rec_target_o,
  output logic [3:0]                         rec_type_o,
  output logic [CcWidth-1:0]                 rec_cc_o,
  output logic                               rec_ccv_o,
  output logic                               overflow_o,
  output logic [$clog2(FifoDepth):0]         count_o
);
  localparam int unsigned N  = NrCommitPorts;
  localparam int unsigned AW = $clog2(FifoDepth);
  localparam int unsigned CW = AW + 1;
  localparam logic [CcWidth-1:0] CcMax = '1;

  typedef struct packed {
    logic [XLEN-2:0] src;
    logic [XLEN-2:0] tgt;
    logic [3:0]      typ;
  } cand_t;

  typedef struct packed {
    cand_t              body;
    logic [CcWidth-1:0] cc;
    logic               ccv;
  } rec_t;

  logic [N-1:0][XLEN-1:0] pc;
  logic [N-1:0][3:0]      ty;
  assign pc = source_i;
  assign ty = type_i;

  // Bit 0 of a PC is never recorded.
  logic unused_pc_lsb;
  always_comb begin
    unused_pc_lsb = 1'b0;
    for (int i = 0; i < int'(N); i++) unused_pc_lsb = unused_pc_lsb ^ pc[i][0];
  end

  // State
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               pend_vld_q, pend_vld_d;
  logic [XLEN-2:0]    pend_src_q, pend_src_d;
  logic [3:0]         pend_type_q, pend_type_d;
  logic [CcWidth-1:0] cc_q, cc_d;
  logic               started_q, started_d;
  rec_t               mem_q [FifoDepth];

  // Candidate list in program order: slot 0 completes the pending transfer,
  // slot i+1 pairs port i with port i+1 in the same cycle.
  cand_t [N-1:0] cand;
  logic  [N-1:0] cand_vld, keep;
  always_comb begin
    cand     = '0;
    cand_vld = '0;
    cand_vld[0]    = pend_vld_q & valid_i[0];
    cand[0].src    = pend_src_q;
    cand[0].tgt    = pc[0][XLEN-1:1];
    cand[0].typ    = pend_type_q;
    for (int i = 0; i < int'(N) - 1; i++) begin
      cand_vld[i+1] = valid_i[i] & (ty[i] != 4'd0) & valid_i[i+1];
      cand[i+1].src = pc[i][XLEN-1:1];
      cand[i+1].tgt = pc[i+1][XLEN-1:1];
      cand[i+1].typ = ty[i];
    end
  end

  for (genvar c = 0; c < int'(N); c++) begin : g_filt
    ctr_record_queue_filt u_filt (
      .vld_i          (cand_vld[c]),
      .type_i         (cand[c].typ),
      .inhibit_mask_i (inhibit_mask_i),
      .freeze_i       (freeze_i),
      .keep_o         (keep[c])
    );
  end

  logic          pop;
  logic [CW-1:0] free, nw;
  logic          drop;
  logic [N-1:0]  wr_en;
  logic [N-1:0][AW-1:0] wr_addr;
  rec_t [N-1:0]  wr_rec;

  assign rec_valid_o = (count_q != '0);
  assign pop         = rec_valid_o & rec_ready_i;
  assign free        = CW'(FifoDepth) - count_q + CW'(pop);

  // Pack kept candidates into consecutive FIFO slots until space runs out;
  // only the first write of a cycle carries the running cycle count.
  always_comb begin
    nw      = '0;
    drop    = 1'b0;
    wr_en   = '0;
    wr_addr = '0;
    wr_rec  = '0;
    for (int c = 0; c < int'(N); c++) begin
      wr_rec[c].body = cand[c];
      wr_addr[c]     = wr_ptr_q + nw[AW-1:0];
      if (nw == '0) begin
        wr_rec[c].cc  = cc_q;
        wr_rec[c].ccv = started_q & (cc_q != CcMax);
      end else begin
        wr_rec[c].cc  = '0;
        wr_rec[c].ccv = 1'b1;
      end
      if (keep[c]) begin
        if (nw < free) begin
          wr_en[c] = 1'b1;
          nw       = nw + CW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  // Next state for pointers, pending slot and cycle counter; flush wins.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + nw[AW-1:0];
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + nw - CW'(pop);
    ovf_d       = ovf_q | drop;
    pend_vld_d  = pend_vld_q;
    pend_src_d  = pend_src_q;
    pend_type_d = pend_type_q;
    if (valid_i[0]) begin
      pend_vld_d = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        if (valid_i[i]) begin
          pend_vld_d  = (ty[i] != 4'd0);
          pend_src_d  = pc[i][XLEN-1:1];
          pend_type_d = ty[i];
        end
      end
    end
    if (nw != '0)          cc_d = CcWidth'(1);
    else if (cc_q == CcMax) cc_d = cc_q;
    else                    cc_d = cc_q + CcWidth'(1);
    started_d = started_q | (nw != '0);
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ovf_d      = 1'b0;
      pend_vld_d = 1'b0;
      cc_d       = '0;
      started_d  = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_src_q  <= '0;
      pend_type_q <= '0;
      cc_q        <= '0;
      started_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      pend_vld_q  <= pend_vld_d;
      pend_src_q  <= pend_src_d;
      pend_type_q <= pend_type_d;
      cc_q        <= cc_d;
      started_q   <= started_d;
    end
  end

  // Record storage; contents are only observable through the gated head.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < int'(N); c++) begin
      if (wr_en[c] && !flush_i) mem_q[wr_addr[c]] <= wr_rec[c];
    end
  end

  rec_t head;
  assign head         = rec_valid_o ? mem_q[rd_ptr_q] : '0;
  assign rec_source_o = head.body.src;
  assign rec_target_o = head.body.tgt;
  assign rec_type_o   = head.body.typ;
  assign rec_cc_o     = head.cc;
  assign rec_ccv_o    = head.ccv;
  assign overflow_o   = ovf_q;
  assign count_o      = count_q;
endmodule

// File: tb/tb_ctr_record_queue.sv
// Bench for ctr_record_queue: directed scenarios followed by random traffic,
// all checked each cycle against a queue-based reference model.
module tb_ctr_record_queue;
  localparam int N = 2, XL = 64, D = 4, CCW = 4, CCMAX = 15;
  localparam logic [3:0] BR = 4'h5, CALL = 4'h9, JAL = 4'hB;

  logic clk = 1'b0, rstn = 1'b0;
  logic [N*XL-1:0] source;
  logic [N*4-1:0]  typ;
  logic [N-1:0]    valid;
  logic [15:0]     mask;
  logic            freeze, flush, ready;
  logic            rec_valid, rec_ccv, overflow;
  logic [XL-2:0]   rec_source, rec_target;
  logic [3:0]      rec_type;
  logic [CCW-1:0]  rec_cc;
  logic [2:0]      count;

  always #5 clk = ~clk;

  ctr_record_queue #(.NrCommitPorts(N), .XLEN(XL), .FifoDepth(D), .CcWidth(CCW)) dut (
    .clk_i(clk), .rstn_i(rstn), .source_i(source), .type_i(typ), .valid_i(valid),
    .inhibit_mask_i(mask), .freeze_i(freeze), .flush_i(flush),
    .rec_valid_o(rec_valid), .rec_ready_i(ready), .rec_source_o(rec_source),
    .rec_target_o(rec_target), .rec_type_o(rec_type), .rec_cc_o(rec_cc),
    .rec_ccv_o(rec_ccv), .overflow_o(overflow), .count_o(count)
  );

  typedef struct {
    logic [XL-2:0] src;
    logic [XL-2:0] tgt;
    logic [3:0]    typ;
    int            cc;
    bit            ccv;
  } mrec_t;

  int n_cmp = 0, n_err = 0;
  mrec_t mq[$];
  bit m_pv, m_started, m_ovf;
  logic [XL-2:0] m_psrc;
  logic [3:0] m_ptyp;
  int m_cc;

  function automatic logic [XL-2:0] pc1(int i);
    return source[i*XL+1 +: XL-1];
  endfunction

  function automatic logic [3:0] ty(int i);
    return typ[i*4 +: 4];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pv = 0; m_started = 0; m_ovf = 0; m_cc = 0; m_psrc = '0; m_ptyp = '0;
  endtask

  // One clock of the reference behaviour, using the inputs currently driven.
  task automatic model_step();
    mrec_t c[$];
    mrec_t r;
    int space, hi;
    bit pushed;
    pushed = 0;
    if (flush) begin
      model_reset();
      return;
    end
    space = D - mq.size();
    if (mq.size() > 0 && ready) begin
      void'(mq.pop_front());
      space++;
    end
    if (m_pv && valid[0]) begin
      r.src = m_psrc; r.tgt = pc1(0); r.typ = m_ptyp; r.cc = 0; r.ccv = 0;
      c.push_back(r);
    end
    for (int i = 0; i < N - 1; i++) begin
      if (valid[i] && ty(i) != 0 && valid[i+1]) begin
        r.src = pc1(i); r.tgt = pc1(i+1); r.typ = ty(i); r.cc = 0; r.ccv = 0;
        c.push_back(r);
      end
    end
    foreach (c[k]) begin
      if (!freeze && !mask[c[k].typ]) begin
        if (space == 0) m_ovf = 1;
        else begin
          c[k].cc  = pushed ? 0 : m_cc;
          c[k].ccv = pushed ? 1'b1 : (m_started && m_cc != CCMAX);
          mq.push_back(c[k]);
          space--;
          pushed = 1;
        end
      end
    end
    if (valid[0]) begin
      hi = 0;
      for (int i = 0; i < N; i++) if (valid[i]) hi = i;
      m_pv = (ty(hi) != 0); m_psrc = pc1(hi); m_ptyp = ty(hi);
    end
    m_cc = pushed ? 1 : (m_cc < CCMAX ? m_cc + 1 : CCMAX);
    m_started = m_started | pushed;
  endtask

  task automatic compare_all();
    bit v;
    v = (mq.size() != 0);
    chk("count", 64'(count), 64'(mq.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("rec_valid", 64'(rec_valid), 64'(v));
    if (v) begin
      chk("rec_source", 64'(rec_source), 64'(mq[0].src));
      chk("rec_target", 64'(rec_target), 64'(mq[0].tgt));
      chk("rec_type", 64'(rec_type), 64'(mq[0].typ));
      chk("rec_cc", 64'(rec_cc), 64'(mq[0].cc));
      chk("rec_ccv", 64'(rec_ccv), 64'(mq[0].ccv));
    end else begin
      chk("idle_fields", {rec_source[59:0], rec_type}, 64'd0);
      chk("idle_tgt_cc", {rec_target[58:0], rec_cc, rec_ccv}, 64'd0);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                       input logic [3:0] t0, input logic [3:0] t1);
    valid = v;
    source = {p1, p0};
    typ = {t1, t0};
  endtask

  task automatic idle();
    drive('0, 64'd0, 64'd0, 4'd0, 4'd0);
  endtask

  int nv;

  initial begin
    idle();
    mask = '0; freeze = 0; flush = 0; ready = 0;
    #2;
    model_reset();
    compare_all();
    @(negedge clk) rstn = 1;

    // Same-cycle pair
    drive(2'b11, 64'h1000, 64'h2000, JAL, 4'd0);
    tick();
    chk("tp1_src", 64'(rec_source), 64'h800);
    chk("tp1_tgt", 64'(rec_target), 64'h1000);
    chk("tp1_type", 64'(rec_type), 64'(JAL));
    chk("tp1_ccv", 64'(rec_ccv), 64'd0);
    idle(); ready = 1;
    tick();

    // Cross-cycle completion after idle cycles
    drive(2'b11, 64'h3000, 64'h3004, 4'd0, BR);
    tick();
    idle();
    repeat (3) tick();
    drive(2'b01, 64'h4000, 64'h0, 4'd0, 4'd0);
    tick();
    chk("tp2_count", 64'(count), 64'd1);
    chk("tp2_src", 64'(rec_source), 64'h1802);
    chk("tp2_tgt", 64'(rec_target), 64'h2000);
    chk("tp2_cc", 64'(rec_cc), 64'd6);
    chk("tp2_ccv", 64'(rec_ccv), 64'd1);

    // Overflow with a stalled consumer, then flush
    idle(); flush = 1;
    tick();
    flush = 0; ready = 0;
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, 64'h8000 + 64'(k*16), 64'h8004 + 64'(k*16), JAL, 4'd0);
      tick();
    end
    chk("tp3_count", 64'(count), 64'd4);
    chk("tp3_ovf", 64'(overflow), 64'd1);
    chk("tp3_head", 64'(rec_source), 64'h4000);
    idle(); flush = 1;
    tick();
    flush = 0;
    chk("tp3_flush_count", 64'(count), 64'd0);
    chk("tp3_flush_ovf", 64'(overflow), 64'd0);

    // Inhibit then freeze; pending target still resolves
    mask = 16'h1 << JAL;
    drive(2'b11, 64'h5000, 64'h5004, JAL, CALL);
    tick();
    chk("tp4_inhibit", 64'(count), 64'd0);
    mask = '0; freeze = 1;
    drive(2'b11, 64'h6000, 64'h6004, 4'd0, BR);
    tick();
    chk("tp4_freeze", 64'(count), 64'd0);
    freeze = 0;
    drive(2'b01, 64'h7000, 64'h0, 4'd0, 4'd0);
    tick();
    chk("tp4_count", 64'(count), 64'd1);
    chk("tp4_src", 64'(rec_source), 64'h3002);
    chk("tp4_tgt", 64'(rec_target), 64'h3800);
    chk("tp4_type", 64'(rec_type), 64'(BR));

    // Full FIFO with simultaneous pop and push
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 64'h9000 + 64'(k*8), 64'h9004 + 64'(k*8), JAL, 4'd0);
      tick();
    end
    chk("tp5_full", 64'(count), 64'd4);
    ready = 1;
    drive(2'b11, 64'hA000, 64'hA004, JAL, 4'd0);
    tick();
    chk("tp5_count", 64'(count), 64'd4);
    chk("tp5_ovf", 64'(overflow), 64'd0);

    // Cycle counter saturation
    idle(); flush = 1;
    tick();
    flush = 0;
    repeat (20) tick();
    drive(2'b11, 64'hB000, 64'hB004, JAL, 4'd0);
    tick();
    chk("tp6_cc", 64'(rec_cc), 64'd15);
    chk("tp6_ccv", 64'(rec_ccv), 64'd0);

    // Random traffic with a mid-run asynchronous reset
    for (int cyc = 0; cyc < 400; cyc++) begin
      nv = $urandom_range(0, N);
      valid = N'((1 << nv) - 1);
      source = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < N; i++)
        typ[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      mask   = ($urandom_range(0, 3) == 0) ? (16'h1 << $urandom_range(1, 15)) : 16'h0;
      freeze = ($urandom_range(0, 15) == 0);
      flush  = ($urandom_range(0, 49) == 0);
      ready  = ($urandom_range(0, 2) == 0);
      tick();
      if (cyc == 200) begin
        rstn = 0;
        #2;
        model_reset();
        compare_all();
        idle(); flush = 0;
        @(negedge clk) rstn = 1;
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
